// File: rtl/cronometro_pkg.sv
// Shared state encodings and BCD limits for the stopwatch sequencing controller.
package cronometro_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;
    localparam logic [BCD_W-1:0] MIN_MAX   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // A preset is loadable only if every digit is a legal BCD value for its position.
    function automatic logic bcd_preset_ok(input logic [BCD_W-1:0] u,
                                           input logic [BCD_W-1:0] t,
                                           input logic [BCD_W-1:0] m);
        return (u <= UNITS_MAX) && (t <= TENS_MAX) && (m <= MIN_MAX);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-tick prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise, synchronous zero.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_zero,
    output logic o_term
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_zero) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch sequencing controller: tick generation, start/pause/reset/load FSM and digit strobes.
// Optional lap-hold display feature compiled in with CRONOMETRO_CTRL_LAP_EN.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_reset,
    input  logic       btn_load,
    input  logic       btn_lap,
    input  logic [3:0] preset_u,
    input  logic [3:0] preset_t,
    input  logic [3:0] preset_m,
    input  logic [3:0] q_u,
    input  logic [3:0] q_t,
    input  logic [3:0] q_m,
    output logic       tick,
    output logic [3:0] pre_u,
    output logic [3:0] pre_t,
    output logic [3:0] pre_m,
    output logic [3:0] clr_u,
    output logic [3:0] clr_t,
    output logic [3:0] clr_m,
    output logic [1:0] state,
    output logic       limit,
    output logic       load_err,
    output logic [3:0] disp_u,
    output logic [3:0] disp_t,
    output logic [3:0] disp_m,
    output logic       lap_active
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_tick;
    logic       r_limit;
    logic       r_load_err;
    logic [3:0] r_pre_u, r_pre_t, r_pre_m;
    logic [3:0] r_clr_u, r_clr_t, r_clr_m;
    logic [3:0] r_disp_u, r_disp_t, r_disp_m;

    logic w_term;
    logic w_at_max;
    logic w_preset_ok;
    logic w_clr;
    logic w_load;
    logic w_err;
    logic w_tick;
    logic w_limit;
    logic w_zero;
    logic w_en;
    logic w_lap_tgl;
    logic w_release;

    function automatic logic [3:0] pre_bits(input logic load, input logic [3:0] p);
        return load ? p : 4'h0;
    endfunction

    // Clear dominates; a load drives the complement so each bit is either preset or cleared.
    function automatic logic [3:0] clr_bits(input logic clr, input logic load, input logic [3:0] p);
        return clr ? 4'hF : (load ? ~p : 4'h0);
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_zero (w_zero),
        .o_term (w_term)
    );

    assign w_at_max    = (q_m == MIN_MAX) && (q_t == TENS_MAX) && (q_u == UNITS_MAX);
    assign w_preset_ok = bcd_preset_ok(preset_u, preset_t, preset_m);
    assign w_release   = w_clr || w_limit;

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_tick      = 1'b0;
        w_limit     = 1'b0;
        w_zero      = 1'b0;
        w_en        = 1'b0;
        w_lap_tgl   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_reset) begin
                    w_clr = 1'b1;
                end else if (btn_ss) begin
                    w_state_nxt = ST_RUN;
                    w_zero      = 1'b1;
                end else if (btn_load) begin
                    w_load = w_preset_ok;
                    w_err  = !w_preset_ok;
                end
            end
            ST_RUN: begin
                if (btn_reset) begin
                    w_clr       = 1'b1;
                    w_zero      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (btn_ss) begin
                    // Prescaler is frozen on the pause edge so resume continues from this value.
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_en      = 1'b1;
                    w_lap_tgl = btn_lap;
                    if (w_term) begin
                        if (w_at_max) begin
                            w_limit     = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_tick = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_reset) begin
                    w_clr       = 1'b1;
                    w_zero      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (btn_ss) begin
                    w_state_nxt = ST_RUN;
                end else if (btn_load) begin
                    w_load = w_preset_ok;
                    w_err  = !w_preset_ok;
                end else begin
                    w_lap_tgl = btn_lap;
                end
            end
            ST_DONE: begin
                if (btn_reset) begin
                    w_clr       = 1'b1;
                    w_zero      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick     <= 1'b0;
            r_limit    <= 1'b0;
            r_load_err <= 1'b0;
            r_pre_u    <= 4'h0;
            r_pre_t    <= 4'h0;
            r_pre_m    <= 4'h0;
            r_clr_u    <= 4'h0;
            r_clr_t    <= 4'h0;
            r_clr_m    <= 4'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick;
            r_limit    <= w_limit;
            r_load_err <= w_err;
            r_pre_u    <= pre_bits(w_load, preset_u);
            r_pre_t    <= pre_bits(w_load, preset_t);
            r_pre_m    <= pre_bits(w_load, preset_m);
            r_clr_u    <= clr_bits(w_clr, w_load, preset_u);
            r_clr_t    <= clr_bits(w_clr, w_load, preset_t);
            r_clr_m    <= clr_bits(w_clr, w_load, preset_m);
        end
    end

`ifdef CRONOMETRO_CTRL_LAP_EN
    logic r_lap;
    logic w_hold_keep;

    // The display registers double as the held digits: they stop following q while held.
    assign w_hold_keep = r_lap && !w_release && !w_lap_tgl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap    <= 1'b0;
            r_disp_u <= 4'h0;
            r_disp_t <= 4'h0;
            r_disp_m <= 4'h0;
        end else begin
            if (w_release) begin
                r_lap <= 1'b0;
            end else if (w_lap_tgl) begin
                r_lap <= !r_lap;
            end
            if (!w_hold_keep) begin
                r_disp_u <= q_u;
                r_disp_t <= q_t;
                r_disp_m <= q_m;
            end
        end
    end

    assign lap_active = r_lap;
`else
    logic w_unused_lap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_u <= 4'h0;
            r_disp_t <= 4'h0;
            r_disp_m <= 4'h0;
        end else begin
            r_disp_u <= q_u;
            r_disp_t <= q_t;
            r_disp_m <= q_m;
        end
    end

    assign lap_active   = 1'b0;
    assign w_unused_lap = ^{btn_lap, w_lap_tgl, w_release};
`endif

    assign state    = r_state;
    assign tick     = r_tick;
    assign limit    = r_limit;
    assign load_err = r_load_err;
    assign pre_u    = r_pre_u;
    assign pre_t    = r_pre_t;
    assign pre_m    = r_pre_m;
    assign clr_u    = r_clr_u;
    assign clr_t    = r_clr_t;
    assign clr_m    = r_clr_m;
    assign disp_u   = r_disp_u;
    assign disp_t   = r_disp_t;
    assign disp_m   = r_disp_m;

endmodule
